// File: rtl/cf_multi_if.sv
// Sample-vector handshake and filtered-angle result bus for cf_multi.
// Carries no state or latency of its own.
// The master drives in_valid and data; the slave answers with in_ready and the out_valid strobe.
interface cf_multi_if #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*DATA_W-1:0]   gyro_in;
    logic [CHANNELS*DATA_W-1:0]   accel_in;
    logic                         out_valid;
    logic [CHANNELS*DATA_W-1:0]   angle_out;

    modport master (
        output in_valid,
        output gyro_in,
        output accel_in,
        input  in_ready,
        input  out_valid,
        input  angle_out
    );

    modport slave (
        input  in_valid,
        input  gyro_in,
        input  accel_in,
        output in_ready,
        output out_valid,
        output angle_out
    );
endinterface

// File: rtl/cf_multi.sv
// Multi-channel complementary filter: one shared blend datapath, time-multiplexed per channel.
// Latency: out_valid strobes CHANNELS+1 cycles after the accept edge; one vector per CHANNELS+2 cycles.
// Backpressure: in_ready is high only in IDLE. Macro CF_SAT_EN selects clamping instead of wrapping.
module cf_multi #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 3,
    parameter int FRAC_W   = 8,
    parameter int ALPHA    = 230,
    parameter int DT_SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    cf_multi_if.slave  bus
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW   = DATA_W + 1;           // integrator width
    localparam int MW   = DATA_W + FRAC_W + 2;  // blend accumulator width

    localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic signed [MW-1:0] GYRO_WT  = MW'(ALPHA);
    localparam logic signed [MW-1:0] ACCEL_WT = MW'((1 << FRAC_W) - ALPHA);

`ifdef CF_SAT_EN
    localparam logic signed [IW:0]   INTEG_MAX = (IW+1)'((1 << DATA_W) - 1);
    localparam logic signed [IW:0]   INTEG_MIN = (IW+1)'(-(1 << DATA_W));
    localparam logic signed [MW-1:0] RES_MAX   = MW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [MW-1:0] RES_MIN   = MW'(-(1 << (DATA_W - 1)));
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [CH_W-1:0]           ch;
    logic                      seeded;
    logic signed [DATA_W-1:0]  gyro_r  [CHANNELS];
    logic signed [DATA_W-1:0]  accel_r [CHANNELS];
    logic signed [DATA_W-1:0]  angle_q [CHANNELS];
    logic                      out_valid_q;
    logic [CHANNELS*DATA_W-1:0] angle_out_q;

    logic signed [DATA_W-1:0]  cur_gyro;
    logic signed [DATA_W-1:0]  cur_accel;
    logic signed [DATA_W-1:0]  cur_angle;
    logic signed [IW-1:0]      integ;
    logic signed [MW-1:0]      mix;
    logic signed [DATA_W-1:0]  angle_next;
`ifdef CF_SAT_EN
    logic signed [IW:0]        integ_wide;
    logic signed [MW-1:0]      res_wide;
`endif

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.angle_out = angle_out_q;

    // Shared blend datapath for the channel selected by ch.
    always_comb begin
        cur_gyro   = gyro_r[ch];
        cur_accel  = accel_r[ch];
        cur_angle  = angle_q[ch];
`ifdef CF_SAT_EN
        integ_wide = (IW+1)'(cur_angle) + (IW+1)'(cur_gyro >>> DT_SHIFT);
        if (integ_wide > INTEG_MAX) begin
            integ = INTEG_MAX[IW-1:0];
        end else if (integ_wide < INTEG_MIN) begin
            integ = INTEG_MIN[IW-1:0];
        end else begin
            integ = integ_wide[IW-1:0];
        end
        mix      = GYRO_WT * MW'(integ) + ACCEL_WT * MW'(cur_accel);
        res_wide = mix >>> FRAC_W;
        if (res_wide > RES_MAX) begin
            angle_next = RES_MAX[DATA_W-1:0];
        end else if (res_wide < RES_MIN) begin
            angle_next = RES_MIN[DATA_W-1:0];
        end else begin
            angle_next = res_wide[DATA_W-1:0];
        end
`else
        integ      = IW'(cur_angle) + IW'(cur_gyro >>> DT_SHIFT);
        mix        = GYRO_WT * MW'(integ) + ACCEL_WT * MW'(cur_accel);
        angle_next = DATA_W'(mix >>> FRAC_W);
`endif
        // First vector after reset seeds the state straight from the accelerometer.
        if (!seeded) begin
            angle_next = cur_accel;
        end
    end

    // Control FSM: capture on handshake, walk the channels, then publish the vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ch          <= '0;
            seeded      <= 1'b0;
            out_valid_q <= 1'b0;
            angle_out_q <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                gyro_r[k]  <= '0;
                accel_r[k] <= '0;
                angle_q[k] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            gyro_r[k]  <= bus.gyro_in[k*DATA_W +: DATA_W];
                            accel_r[k] <= bus.accel_in[k*DATA_W +: DATA_W];
                        end
                        ch    <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    angle_q[ch] <= angle_next;
                    if (ch == LAST_CH) begin
                        state <= S_DONE;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                S_DONE: begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        angle_out_q[k*DATA_W +: DATA_W] <= angle_q[k];
                    end
                    out_valid_q <= 1'b1;
                    seeded      <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cf_multi.sv
// Self-checking bench for cf_multi with default parameters.
// Reference model is plain integer arithmetic over per-channel angle state.
// Covers seeding, blend, floor rounding, overflow, back-to-back handshake and mid-vector reset.
module tb_cf_multi;

    localparam int DATA_W   = 16;
    localparam int CHANNELS = 3;
    localparam int FRAC_W   = 8;
    localparam int ALPHA    = 230;
    localparam int DT_SHIFT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] m_angle [3];
    bit          m_seeded;

    cf_multi_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) bus ();

    cf_multi #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .FRAC_W(FRAC_W),
        .ALPHA(ALPHA), .DT_SHIFT(DT_SHIFT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // One filter step from the arithmetic rules, on plain integers.
    function automatic logic [15:0] model_step(logic [15:0] ang, logic [15:0] g, logic [15:0] a, bit seeded);
        int ai, gi, ci, integ, mix, res;
        if (!seeded) return a;
        ai = $signed(ang);
        gi = $signed(g);
        ci = $signed(a);
        integ = ai + (gi >>> DT_SHIFT);
`ifdef CF_SAT_EN
        if (integ > 65535) integ = 65535;
        if (integ < -65536) integ = -65536;
`endif
        mix = ALPHA * integ + ((1 << FRAC_W) - ALPHA) * ci;
        res = mix >>> FRAC_W;
`ifdef CF_SAT_EN
        if (res > 32767) res = 32767;
        if (res < -32768) res = -32768;
`endif
        return res[15:0];
    endfunction

    function automatic logic [47:0] model_apply(logic [47:0] g, logic [47:0] a);
        for (int k = 0; k < 3; k++)
            m_angle[k] = model_step(m_angle[k], g[k*16 +: 16], a[k*16 +: 16], m_seeded);
        m_seeded = 1'b1;
        return {m_angle[2], m_angle[1], m_angle[0]};
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) m_angle[k] = '0;
        m_seeded = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Push one vector, scramble inputs during CALC, check timing and result.
    task automatic run_vector(input logic [47:0] g, input logic [47:0] a, input string name,
                              output logic [47:0] got);
        int waited;
        logic [47:0] exp;
        waited = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", name, bus.in_ready);
        end
        bus.gyro_in  = g;
        bus.accel_in = a;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.gyro_in  = rand48();
        bus.accel_in = rand48();
        exp = model_apply(g, a);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_cycle%0d: in_ready=%b out_valid=%b required 0/0",
                         name, i, bus.in_ready, bus.out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s strobe: out_valid=%b in_ready=%b required 1/1",
                     name, bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.angle_out !== exp) begin
            errors++;
            $display("FAIL %s angle: got %h required %h", name, bus.angle_out, exp);
        end
        got = bus.angle_out;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.angle_out !== exp) begin
            errors++;
            $display("FAIL %s hold: out_valid=%b angle=%h required 0/%h",
                     name, bus.out_valid, bus.angle_out, exp);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.gyro_in  = '0;
        bus.accel_in = '0;
        for (int k = 0; k < 3; k++) m_angle[k] = '0;
        m_seeded = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.angle_out !== 48'h0) begin
            errors++;
            $display("FAIL reset_out: out_valid=%b angle=%h required 0/0", bus.out_valid, bus.angle_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seed();
        logic [47:0] got;
        run_vector({16'h0001, 16'h0001, 16'h0001}, {16'hE000, 16'h2000, 16'h2800}, "seed", got);
        checks++;
        if (got !== 48'hE000_2000_2800) begin
            errors++;
            $display("FAIL seed_const: got %h required e00020002800", got);
        end
    endtask

    task automatic test_blend();
        logic [47:0] got;
        run_vector({16'h0000, 16'h0000, 16'h0100}, {16'hE000, 16'h2000, 16'h2800}, "blend", got);
        checks++;
        if (got !== 48'hE000_2000_280E) begin
            errors++;
            $display("FAIL blend_const: got %h required e0002000280e", got);
        end
    endtask

    task automatic test_neg_floor();
        logic [47:0] got;
        run_vector({16'hFFF0, 16'h0000, 16'h0000}, {16'hE000, 16'h2000, 16'h280E}, "negfloor", got);
        checks++;
        if (got !== 48'hDFFF_2000_280E) begin
            errors++;
            $display("FAIL negfloor_const: got %h required dfff2000280e", got);
        end
    endtask

    task automatic test_overflow();
        logic [47:0] got;
        logic [15:0] want;
`ifdef CF_SAT_EN
        want = 16'h7FFF;
`else
        want = 16'h871F;
`endif
        pulse_reset();
        run_vector(48'h0, {16'h0000, 16'h0000, 16'h7FF0}, "ovf_seed", got);
        run_vector({16'h0000, 16'h0000, 16'h7FFF}, {16'h0000, 16'h0000, 16'h7FF0}, "ovf", got);
        checks++;
        if (got[15:0] !== want) begin
            errors++;
            $display("FAIL ovf_const: ch0 got %h required %h", got[15:0], want);
        end
    endtask

    task automatic test_random();
        logic [47:0] got, g, a;
        for (int n = 0; n < 10; n++) begin
            g = rand48();
            if (n < 5) begin
                a = {16'($urandom_range(0, 8191) - 4096), 16'($urandom_range(0, 8191) - 4096),
                     16'($urandom_range(0, 8191) - 4096)};
            end else begin
                a = rand48();
            end
            run_vector(g, a, "random", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] vg [6];
        logic [47:0] va [6];
        logic [47:0] exp;
        int prev_acc, acc, waited;
        for (int i = 0; i < 6; i++) begin
            vg[i] = rand48();
            va[i] = rand48();
        end
        prev_acc = 0;
        waited = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.in_valid = 1'b1;
        bus.gyro_in  = vg[0];
        bus.accel_in = va[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (i > 0) begin
                checks++;
                if (acc - prev_acc !== 5) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles required 5", i, acc - prev_acc);
                end
            end
            prev_acc = acc;
            exp = model_apply(vg[i], va[i]);
            bus.gyro_in  = rand48();
            bus.accel_in = rand48();
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk);
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy%0d_%0d: in_ready=%b required 0", i, j, bus.in_ready);
                end
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.angle_out !== exp) begin
                errors++;
                $display("FAIL b2b_result%0d: out_valid=%b angle=%h required 1/%h",
                         i, bus.out_valid, bus.angle_out, exp);
            end
            if (i < 5) begin
                bus.gyro_in  = vg[i+1];
                bus.accel_in = va[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] got, g, a;
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.in_valid = 1'b1;
        bus.gyro_in  = rand48();
        bus.accel_in = rand48();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) m_angle[k] = '0;
        m_seeded = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.angle_out !== 48'h0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: out_valid=%b angle=%h in_ready=%b required 0/0/1",
                     bus.out_valid, bus.angle_out, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_hold: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b1;
        g = rand48();
        a = rand48();
        run_vector(g, a, "reseed", got);
        checks++;
        if (got !== a) begin
            errors++;
            $display("FAIL reseed_accel: got %h required %h", got, a);
        end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_blend();
        test_neg_floor();
        test_random();
        test_back_to_back();
        test_overflow();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
